// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction word per cycle, resolves
// B/CBZ/CBNZ targets, and halts when the next PC would leave instruction memory.
module pc_sequencer #(
    parameter int BITSIZE   = 32,
    parameter int REGSIZE   = 64,
    parameter int MEM_DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [BITSIZE-1:0] Instruction,
    input  logic [REGSIZE-1:0] RtValue,
    output logic [REGSIZE-1:0] Address,
    output logic [4:0]         RtAddr,
    output logic [BITSIZE-1:0] IR,
    output logic               IRValid,
    output logic               Halted,
    output logic [15:0]        InstrCount
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [REGSIZE-1:0] PC_LIMIT = REGSIZE'(MEM_DEPTH);
    localparam logic [15:0]        CNT_MAX  = 16'hFFFF;

    state_t               state_reg;
    logic [REGSIZE-1:0]   pc_reg;
    logic [BITSIZE-1:0]   ir_reg;
    logic                 ir_valid_reg;
    logic                 halted_reg;
    logic [15:0]          count_reg;

    logic                 is_b;
    logic                 is_cbz;
    logic                 is_cbnz;
    logic                 rt_zero;
    logic                 taken;
    logic [REGSIZE-1:0]   offset;
    logic [REGSIZE-1:0]   pc_next;
    logic                 pc_out_of_range;

    // Opcode decode and branch resolution, all from the current word.
    always_comb begin
        is_b    = (Instruction[31:26] == 6'b000101);
        is_cbz  = (Instruction[31:24] == 8'b10110100);
        is_cbnz = (Instruction[31:24] == 8'b10110101);
        rt_zero = (RtValue == '0);

        taken  = 1'b0;
        offset = '0;
        if (is_b) begin
            taken  = 1'b1;
            offset = {{(REGSIZE-26){Instruction[25]}}, Instruction[25:0]};
        end else if (is_cbz || is_cbnz) begin
            taken  = is_cbz ? rt_zero : !rt_zero;
            offset = {{(REGSIZE-19){Instruction[23]}}, Instruction[23:5]};
        end

        // Negative offsets wrap to large unsigned values and trip the range check.
        pc_next         = taken ? (pc_reg + offset) : (pc_reg + REGSIZE'(1));
        pc_out_of_range = (pc_next >= PC_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_RUN;
            pc_reg       <= '0;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            halted_reg   <= 1'b0;
            count_reg    <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (stall) begin
                        ir_valid_reg <= 1'b0;
                    end else begin
                        ir_reg       <= Instruction;
                        ir_valid_reg <= 1'b1;
                        if (count_reg != CNT_MAX) begin
                            count_reg <= count_reg + 16'd1;
                        end
                        // The faulting instruction still retires; only the PC update is suppressed.
                        if (pc_out_of_range) begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            pc_reg <= pc_next;
                        end
                    end
                end
                ST_HALT: begin
                    ir_valid_reg <= 1'b0;
                    halted_reg   <= 1'b1;
                end
                default: begin
                    state_reg    <= ST_HALT;
                    ir_valid_reg <= 1'b0;
                    halted_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign Address    = pc_reg;
    assign RtAddr     = Instruction[4:0];
    assign IR         = ir_reg;
    assign IRValid    = ir_valid_reg;
    assign Halted     = halted_reg;
    assign InstrCount = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized programs, all checked
// against an arithmetic reference model of the sequencer.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] Instruction;
    logic [63:0] RtValue;
    logic [63:0] Address;
    logic [4:0]  RtAddr;
    logic [31:0] IR;
    logic        IRValid;
    logic        Halted;
    logic [15:0] InstrCount;

    logic [31:0] mem  [64];
    logic [63:0] regs [32];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic [31:0] m_ir;
    logic        m_valid;
    logic        m_halted;
    int          m_count;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .Instruction(Instruction),
        .RtValue    (RtValue),
        .Address    (Address),
        .RtAddr     (RtAddr),
        .IR         (IR),
        .IRValid    (IRValid),
        .Halted     (Halted),
        .InstrCount (InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Instruction = mem[Address[5:0]];
    assign RtValue     = regs[RtAddr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input int off);
        logic [25:0] f;
        f = 26'(off);
        return {6'b000101, f};
    endfunction

    function automatic logic [31:0] enc_cb(input bit nz, input int off, input int rt);
        logic [18:0] f;
        logic [4:0]  r;
        f = 19'(off);
        r = 5'(rt);
        return {(nz ? 8'hB5 : 8'hB4), f, r};
    endfunction

    function automatic logic [31:0] enc_plain();
        logic [23:0] low;
        low = 24'($urandom);
        return {8'h8B, low};
    endfunction

    // Signed value of an n-bit field, computed arithmetically.
    function automatic longint field_signed(input longint raw, input int nbits);
        longint half;
        half = longint'(1) << (nbits - 1);
        return (raw >= half) ? raw - (half << 1) : raw;
    endfunction

    task automatic model_edge(input logic rst, input logic stl);
        logic [31:0] ins;
        longint      off;
        logic [63:0] tgt;
        bit          br;
        if (rst) begin
            m_pc = 0; m_ir = 0; m_valid = 0; m_halted = 0; m_count = 0;
        end else if (m_halted || stl) begin
            m_valid = 0;
        end else begin
            ins = mem[m_pc[5:0]];
            br  = 0;
            off = 0;
            if (ins[31:26] == 6'b000101) begin
                br  = 1;
                off = field_signed(longint'(ins[25:0]), 26);
            end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5) begin
                off = field_signed(longint'(ins[23:5]), 19);
                br  = (ins[31:24] == 8'hB4) ? (regs[ins[4:0]] == 0) : (regs[ins[4:0]] != 0);
            end
            tgt = br ? m_pc + 64'(off) : m_pc + 64'd1;
            m_ir    = ins;
            m_valid = 1;
            if (m_count < 65535) m_count++;
            if (tgt >= 64) m_halted = 1;
            else m_pc = tgt;
        end
    endtask

    task automatic compare_all();
        check("Address",    Address,    m_pc);
        check("IR",         64'(IR),    64'(m_ir));
        check("IRValid",    64'(IRValid), 64'(m_valid));
        check("Halted",     64'(Halted),  64'(m_halted));
        check("InstrCount", 64'(InstrCount), 64'(m_count));
        check("RtAddr",     64'(RtAddr),  64'(mem[m_pc[5:0]][4:0]));
    endtask

    task automatic step(input logic rst, input logic stl);
        @(negedge clk);
        reset = rst;
        stall = stl;
        @(posedge clk);
        model_edge(rst, stl);
        #1;
        compare_all();
        $display("[TB] rst=%0b stall=%0b addr=%0d ir=%08h v=%0b halt=%0b cnt=%0d",
                 rst, stl, Address, IR, IRValid, Halted, InstrCount);
    endtask

    task automatic fill_plain();
        for (int i = 0; i < 64; i++) mem[i] = enc_plain();
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        fill_plain();
        m_pc = 0; m_ir = 0; m_valid = 0; m_halted = 0; m_count = 0;

        // Sequential fetch from reset
        step(1'b1, 1'b0);
        check("rst_addr", Address, 64'd0);
        check("rst_cnt", 64'(InstrCount), 64'd0);
        run(4);
        check("seq_addr", Address, 64'd4);
        check("seq_cnt", 64'(InstrCount), 64'd4);

        // Forward and backward B
        fill_plain();
        mem[5] = enc_b(3);
        mem[8] = enc_b(-8);
        step(1'b1, 1'b0);
        run(6);
        check("b_fwd", Address, 64'd8);
        run(1);
        check("b_back", Address, 64'd0);

        // CBNZ taken / not taken, CBZ taken
        fill_plain();
        mem[2] = enc_cb(1'b1, 3, 7);
        regs[7] = 64'd5;
        step(1'b1, 1'b0);
        run(3);
        check("cbnz_taken", Address, 64'd5);
        regs[7] = 64'd0;
        step(1'b1, 1'b0);
        run(3);
        check("cbnz_fall", Address, 64'd3);
        mem[2] = enc_cb(1'b0, 2, 8);
        regs[8] = 64'd0;
        step(1'b1, 1'b0);
        run(3);
        check("cbz_taken", Address, 64'd4);

        // Self-loop with offset 0 stays in RUN
        mem[1] = enc_b(0);
        step(1'b1, 1'b0);
        run(4);
        check("self_loop_addr", Address, 64'd1);
        check("self_loop_halt", 64'(Halted), 64'd0);

        // Halt at the top of memory
        fill_plain();
        step(1'b1, 1'b0);
        run(63);
        check("top_addr", Address, 64'd63);
        run(1);
        check("top_halt", 64'(Halted), 64'd1);
        check("top_hold", Address, 64'd63);
        check("top_valid", 64'(IRValid), 64'd1);
        run(1);
        check("top_valid_off", 64'(IRValid), 64'd0);
        step(1'b0, 1'b1);

        // Reset in HALT with stall asserted
        step(1'b1, 1'b1);
        check("rst_halt_addr", Address, 64'd0);
        check("rst_halt_h", 64'(Halted), 64'd0);
        check("rst_halt_ir", 64'(IR), 64'd0);

        // Negative branch below zero halts
        mem[2] = enc_b(-10);
        step(1'b1, 1'b0);
        run(3);
        check("neg_halt", 64'(Halted), 64'd1);
        check("neg_addr", Address, 64'd2);

        // Stall at PC 4
        fill_plain();
        step(1'b1, 1'b0);
        run(4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check("stall_addr", Address, 64'd4);
            check("stall_cnt", 64'(InstrCount), 64'd4);
        end
        run(1);
        check("stall_resume", Address, 64'd5);

        // Randomized programs
        for (int ep = 0; ep < 20; ep++) begin
            for (int i = 0; i < 64; i++) begin
                int sel;
                int off;
                sel = int'($urandom_range(0, 9));
                off = int'($urandom_range(0, 12)) - 6;
                case (sel)
                    6: mem[i] = enc_b(off);
                    7: mem[i] = enc_cb(1'b0, off, int'($urandom_range(0, 31)));
                    8: mem[i] = enc_cb(1'b1, off, int'($urandom_range(0, 31)));
                    9: mem[i] = enc_b(int'($urandom_range(0, 80)) - 40);
                    default: mem[i] = enc_plain();
                endcase
            end
            for (int i = 0; i < 32; i++)
                regs[i] = ($urandom_range(0, 1) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            step(1'b1, 1'b0);
            for (int c = 0; c < 150; c++)
                step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 BITSIZE, 32, instruction width in bits.
REQ-002 REGSIZE, 64, PC and register-value width in bits.
REQ-003 MEM_DEPTH, 64, number of instruction words; valid PC range 0..MEM_DEPTH-1.
REQ-004 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  when high, holds all state except the reset path.
REQ-008 Instruction  input  BITSIZE  word read asynchronously from instruction memory at Address.
REQ-009 RtValue  input  REGSIZE  register-file value of Instruction[4:0], combinational from datapath.
REQ-010 Address  output  REGSIZE  current PC, word index, driven to instruction memory.
REQ-011 RtAddr  output  5  Instruction[4:0], combinational.
REQ-012 IR  output  BITSIZE  registered copy of last executed instruction.
REQ-013 IRValid  output  1  high for exactly the cycle after each executed instruction.
REQ-014 Halted  output  1  high while in HALT state.
REQ-015 InstrCount  output  16  number of executed instructions, saturating.

Function
REQ-016 States SHALL be RUN and HALT; reset enters RUN.
REQ-017 PC is a word index; sequential next PC SHALL be PC+1.
REQ-018 In RUN, at each clk edge with stall low, the block SHALL execute Instruction: IR<=Instruction, IRValid<=1, InstrCount<=InstrCount+1 (held at 16'hFFFF once reached), PC<=next PC.
REQ-019 B: Instruction[31:26]==6'b000101; next PC SHALL be PC + sign-extend(Instruction[25:0]).
REQ-020 CBZ: Instruction[31:24]==8'b10110100; next PC SHALL be PC + sign-extend(Instruction[23:5]) if RtValue==0, else PC+1.
REQ-021 CBNZ: Instruction[31:24]==8'b10110101; next PC SHALL be PC + sign-extend(Instruction[23:5]) if RtValue!=0, else PC+1.
REQ-022 Any other encoding SHALL produce next PC = PC+1.
REQ-023 Target arithmetic SHALL be REGSIZE-bit modulo 2^REGSIZE; negative offsets wrap to large unsigned values.
REQ-024 If computed next PC >= MEM_DEPTH (unsigned), the block SHALL still execute the current instruction per REQ-018 but leave PC unchanged and enter HALT.
REQ-025 Offset 0 branch taken SHALL keep PC unchanged and remain in RUN (self-loop, legal).
REQ-026 Stall high in RUN: PC, IR, InstrCount, state hold; IRValid<=0.
REQ-027 In HALT: PC, IR, InstrCount hold; IRValid<=0; Halted=1; stall ignored; exit only by reset.
REQ-028 Address SHALL equal the PC register with zero combinational delay from its flop.
REQ-029 Reset and stall high together: reset SHALL win.

Reset
REQ-030 On reset at a clk edge: PC<=0, IR<=0, IRValid<=0, InstrCount<=0, state<=RUN, Halted<=0.
REQ-031 Reset asserted mid-run or in HALT SHALL apply REQ-030 in full at the next edge; first instruction executed after release is word 0.
REQ-032 No output SHALL change from reset except on a clk edge.

Verification
REQ-033 Sequential: words 0..3 non-branch, reset released -> Address 0,1,2,3 on consecutive cycles; IRValid high each cycle from the first edge; InstrCount=4 after 4 edges.
REQ-034 B forward/backward: word 5 = B +3 -> Address 8 next; word 8 = B -8 (26'h3FFFFF8) -> Address 0 next.
REQ-035 CB: word 2 = CBNZ X7,+3 with RtValue=5 -> Address 5; same with RtValue=0 -> Address 3; CBZ X8,+2 with RtValue=0 -> Address 4.
REQ-036 Halt: PC=63 non-branch -> Halted=1 next cycle, Address stays 63, IRValid=1 for that cycle then 0; B -10 at PC=2 -> HALT with Address 2.
REQ-037 Stall: stall high 3 cycles at PC=4 -> Address 4, IRValid 0, InstrCount unchanged throughout; resumes to 5 after release.
REQ-038 Reset: assert reset in HALT with stall=1 -> next edge Address 0, Halted 0, InstrCount 0, IR 0.
